bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Parametrised successor to the single-counter 2-bit predictor: a PC-indexed branch history table (BHT) of N-bit saturating counters.
- Sits beside fetch. Fetch looks up a prediction combinationally. Execute/resolve writes back the real outcome.
- Adds misprediction detection and a saturating misprediction statistics counter for performance debug.

Parameters:
- PC_W, 32, width of the program counter.
- IDX_W, 6, table index width; the table has 2^IDX_W entries (64).
- CNT_W, 2, width of each saturating counter (minimum 2).
- STAT_W, 16, width of the misprediction statistics counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-low reset.
- pred_pc_i, input, PC_W, PC of the instruction currently in fetch.
- pred_br_i, input, 1, the fetch instruction is a conditional branch; gates the prediction.
- pred_taken_o, output, 1, predicted taken (combinational).
- pred_idx_o, output, IDX_W, table index used for the lookup; the pipeline carries it to resolve.
- upd_valid_i, input, 1, a conditional branch resolves this cycle.
- upd_idx_i, input, IDX_W, index returned from pred_idx_o of that branch.
- upd_taken_i, input, 1, actual outcome of the branch.
- upd_pred_i, input, 1, prediction that was made for that branch.
- mispredict_o, output, 1, registered one-cycle pulse on misprediction.
- mispred_cnt_o, output, STAT_W, saturating count of mispredictions.

Behaviour:
- Reset: synchronous. When rst=0 at a rising edge:
  - every table entry is set to 2^(CNT_W-1) (weakly taken; 2'b10 at default);
  - mispredict_o=0 and mispred_cnt_o=0.
  - Reset has priority over upd_valid_i.
  - Reset mid-operation discards all training, and the reset values hold from the next cycle.
- Index: idx = pred_pc_i[IDX_W+1:2] (word-aligned PCs); pred_idx_o=idx.
- Prediction is combinational with zero latency: pred_taken_o = pred_br_i & table[idx][CNT_W-1]. It is 0 whenever pred_br_i=0.
- Update: when upd_valid_i=1, table[upd_idx_i] changes at the next edge.
  - Taken: increment, saturating at 2^CNT_W-1.
  - Not taken: decrement, saturating at 0.
  - Entries other than upd_idx_i are unchanged.
- Each entry is a saturating counter, states 0 to 2^CNT_W-1. Values at or above 2^(CNT_W-1) predict taken. At default the states are strongly not taken, weakly not taken, weakly taken, strongly taken.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value. The write is visible from the next cycle; there is no bypass.
- Aliasing: PCs with equal idx share one counter. This is intended; there are no tags.
- Misprediction: when upd_valid_i=1 and upd_taken_i!=upd_pred_i, the next cycle has:
  - mispredict_o=1 for exactly one cycle;
  - mispred_cnt_o incremented by 1, saturating at 2^STAT_W-1 with no wrap.
  - Otherwise mispredict_o=0.
- Back-to-back mispredicts on consecutive cycles give consecutive high cycles on mispredict_o, and each one counts.

Optional Feature:
- Macro BHT_GSHARE_EN.
- When defined:
  - An IDX_W-bit global history register ghr, reset to 0, is added.
  - On each upd_valid_i, ghr <= {ghr[IDX_W-2:0], upd_taken_i}. History is updated at resolve only, not speculatively.
  - The lookup index becomes idx = pred_pc_i[IDX_W+1:2] ^ ghr, and pred_idx_o reports this XORed index.
  - A lookup in the same cycle as a ghr update uses the old ghr.
- When undefined: no ghr exists and indexing is PC-only as above.

Test Plan:
1. Reset, then pred_br_i=1 with pred_pc_i=0x100 -> pred_idx_o=0, pred_taken_o=1. Set pred_br_i=0 -> pred_taken_o=0.
2. Three not-taken updates to idx 0 -> counter 2→1→0→0. pred_taken_o=0 after the first. Two taken updates -> 0→1→2, pred_taken_o=1 only after the second.
3. Aliasing: train pc 0x100 to strongly not-taken, then look up pc 0x200 (also idx 0) -> pred_taken_o=0. A lookup of pc 0x104 (idx 1) still predicts 1.
4. Same cycle: update idx 0 not-taken from state 2 while looking up pc 0x100 -> pred_taken_o=1 that cycle, 0 the next.
5. Three consecutive updates with upd_pred_i=1, upd_taken_i=0 -> mispredict_o high for cycles 1–3 after the first update, mispred_cnt_o=3. With STAT_W=2, a fourth mispredict leaves it at 3. Assert rst=0 mid-sequence -> mispred_cnt_o=0 and all entries back to 2.
6. With BHT_GSHARE_EN: reset, then two taken updates -> ghr=6'b000011. Lookup of pc 0x100 -> pred_idx_o=3.

Source files
------------

// File: rtl/bht_predictor.sv
// bht_predictor: PC-indexed table of CNT_W-bit saturating branch counters with misprediction stats.
// Optional macro BHT_GSHARE_EN: XOR the lookup index with a resolve-time global history register.
// Ports:
//   clk, rst (sync, active-low)
//   pred_pc_i, pred_br_i        -> pred_taken_o, pred_idx_o   (combinational lookup)
//   upd_valid_i, upd_idx_i, upd_taken_i, upd_pred_i            (resolve-time training)
//   mispredict_o (registered pulse), mispred_cnt_o (saturating count)
module bht_predictor #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pred_pc_i,
    input  logic              pred_br_i,
    output logic              pred_taken_o,
    output logic [IDX_W-1:0]  pred_idx_o,
    input  logic              upd_valid_i,
    input  logic [IDX_W-1:0]  upd_idx_i,
    input  logic              upd_taken_i,
    input  logic              upd_pred_i,
    output logic              mispredict_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);
    localparam int N = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_INIT = {1'b1, {(CNT_W-1){1'b0}}};

    logic [CNT_W-1:0]  tbl_q [N];
    logic [CNT_W-1:0]  cnt_cur, cnt_d;
    logic [IDX_W-1:0]  idx;
    logic              mis_q, mis_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    logic              unused_pc;

    assign unused_pc = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0]};

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    assign idx = pred_pc_i[IDX_W+1:2] ^ ghr_q;
    // History advances only on resolve, so a same-cycle lookup sees the old value.
    always_ff @(posedge clk) begin
        if (!rst)
            ghr_q <= '0;
        else if (upd_valid_i)
            ghr_q <= {ghr_q[IDX_W-2:0], upd_taken_i};
    end
`else
    assign idx = pred_pc_i[IDX_W+1:2];
`endif

    assign pred_idx_o    = idx;
    assign pred_taken_o  = pred_br_i & tbl_q[idx][CNT_W-1];
    assign mispredict_o  = mis_q;
    assign mispred_cnt_o = stat_q;

    always_comb begin
        cnt_cur = tbl_q[upd_idx_i];
        cnt_d   = upd_taken_i ? ((cnt_cur == '1) ? cnt_cur : cnt_cur + 1'b1)
                              : ((cnt_cur == '0) ? cnt_cur : cnt_cur - 1'b1);
        mis_d   = upd_valid_i & (upd_taken_i ^ upd_pred_i);
        stat_d  = (mis_d && stat_q != '1) ? stat_q + 1'b1 : stat_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++)
                tbl_q[i] <= CNT_INIT;
            mis_q  <= 1'b0;
            stat_q <= '0;
        end else begin
            if (upd_valid_i)
                tbl_q[upd_idx_i] <= cnt_d;
            mis_q  <= mis_d;
            stat_q <= stat_d;
        end
    end
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: directed vectors, hand sequences and a randomized model check of bht_predictor.
module tb_bht_predictor;
    localparam int STAT_W = 3;
    localparam int SMAX = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       pred_pc_i = '0;
    logic              pred_br_i = 1'b0;
    logic              pred_taken_o;
    logic [5:0]        pred_idx_o;
    logic              upd_valid_i = 1'b0;
    logic [5:0]        upd_idx_i = '0;
    logic              upd_taken_i = 1'b0;
    logic              upd_pred_i = 1'b0;
    logic              mispredict_o;
    logic [STAT_W-1:0] mispred_cnt_o;

    bht_predictor #(.PC_W(32), .IDX_W(6), .CNT_W(2), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst),
        .pred_pc_i(pred_pc_i), .pred_br_i(pred_br_i),
        .pred_taken_o(pred_taken_o), .pred_idx_o(pred_idx_o),
        .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i),
        .upd_taken_i(upd_taken_i), .upd_pred_i(upd_pred_i),
        .mispredict_o(mispredict_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer counters and history.
    int m_cnt [64];
    int m_ghr;
    int m_mis;
    int m_stat;

    function automatic int m_idx(input logic [31:0] pc);
        int i;
        i = int'((pc >> 2) & 32'h3F);
`ifdef BHT_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 2;
        m_ghr = 0; m_mis = 0; m_stat = 0;
    endtask

    // Called on a clock edge with the inputs that were present.
    task automatic model_step(input logic uv, input logic [5:0] ui, input logic ut, input logic up);
        m_mis = (uv && ut != up) ? 1 : 0;
        if (m_mis == 1 && m_stat < SMAX) m_stat++;
        if (uv) begin
            if (ut) m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
            else    m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
            m_ghr = ((m_ghr << 1) | int'(ut)) & 63;
        end
    endtask

    task automatic do_reset(input logic uv);
        rst = 1'b0; upd_valid_i = uv; upd_idx_i = 6'd0; upd_taken_i = 1'b0; upd_pred_i = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        chk("reset_mispredict", int'(mispredict_o), 0);
        chk("reset_cnt", int'(mispred_cnt_o), 0);
        rst = 1'b1; upd_valid_i = 1'b0;
    endtask

    // One cycle: drive, sample combinational outputs, clock, sample registered outputs.
    task automatic cycle(input logic [31:0] pc, input logic br, input logic uv, input logic [5:0] ui,
                         input logic ut, input logic up,
                         output int tk, output int ix, output int mi, output int mc,
                         output int e_tk, output int e_ix);
        pred_pc_i = pc; pred_br_i = br; upd_valid_i = uv; upd_idx_i = ui;
        upd_taken_i = ut; upd_pred_i = up;
        #1;
        tk = int'(pred_taken_o); ix = int'(pred_idx_o);
        e_ix = m_idx(pc);
        e_tk = (br && m_cnt[e_ix] >= 2) ? 1 : 0;
        @(posedge clk);
        model_step(uv, ui, ut, up);
        #1;
        mi = int'(mispredict_o); mc = int'(mispred_cnt_o);
        upd_valid_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc; logic br; logic uv; logic [5:0] ui; logic ut; logic up;
        int tk; int ix; int mi; int mc;
    } vec_t;

    initial begin
        vec_t vecs [13];
        int tk, ix, mi, mc, etk, eix;
        vecs[0]  = '{32'h100, 1, 0, 0, 0, 0, 1, 0,  0, 0};
        vecs[1]  = '{32'h100, 0, 0, 0, 0, 0, 0, 0,  0, 0};
        vecs[2]  = '{32'h100, 1, 1, 0, 0, 1, 1, 0,  1, 1};
        vecs[3]  = '{32'h100, 1, 1, 0, 0, 0, 0, 0,  0, 1};
        vecs[4]  = '{32'h100, 1, 1, 0, 0, 0, 0, 0,  0, 1};
        vecs[5]  = '{32'h100, 1, 1, 0, 1, 0, 0, 0,  1, 2};
        vecs[6]  = '{32'h100, 1, 1, 0, 1, 1, 0, 0,  0, 2};
        vecs[7]  = '{32'h100, 1, 0, 0, 0, 0, 1, 0,  0, 2};
        vecs[8]  = '{32'h100, 1, 1, 0, 0, 1, 1, 0,  1, 3};
        vecs[9]  = '{32'h100, 1, 1, 0, 0, 0, 0, 0,  0, 3};
        vecs[10] = '{32'h200, 1, 0, 0, 0, 0, 0, 0,  0, 3};
        vecs[11] = '{32'h104, 1, 0, 0, 0, 0, 1, 1,  0, 3};
        vecs[12] = '{32'h2FC, 1, 0, 0, 0, 0, 1, 63, 0, 3};

        @(posedge clk); #1;
`ifndef BHT_GSHARE_EN
        do_reset(1'b1);
        for (int v = 0; v < 13; v++) begin
            cycle(vecs[v].pc, vecs[v].br, vecs[v].uv, vecs[v].ui, vecs[v].ut, vecs[v].up,
                  tk, ix, mi, mc, etk, eix);
            chk($sformatf("vec%0d_taken", v), tk, vecs[v].tk);
            chk($sformatf("vec%0d_idx", v), ix, vecs[v].ix);
            chk($sformatf("vec%0d_mispredict", v), mi, vecs[v].mi);
            chk($sformatf("vec%0d_cnt", v), mc, vecs[v].mc);
        end
`endif

        // Back-to-back mispredicts, stats saturation, then reset in mid-sequence.
        do_reset(1'b0);
        for (int k = 1; k <= SMAX + 2; k++) begin
            cycle(32'h14, 1, 1, 6'd5, 0, 1, tk, ix, mi, mc, etk, eix);
            chk($sformatf("b2b%0d_mispredict", k), mi, 1);
            chk($sformatf("b2b%0d_cnt", k), mc, (k < SMAX) ? k : SMAX);
        end
        cycle(32'h14, 1, 0, 6'd5, 0, 0, tk, ix, mi, mc, etk, eix);
        chk("b2b_trained_taken", tk, 0);
        chk("b2b_quiet_mispredict", mi, 0);
        chk("b2b_hold_cnt", mc, SMAX);
        do_reset(1'b1);
        cycle(32'h14, 1, 0, 6'd0, 0, 0, tk, ix, mi, mc, etk, eix);
        chk("post_reset_taken", tk, 1);
        chk("post_reset_cnt", mc, 0);

        // Same-cycle lookup and update: old value now, new value next cycle.
        cycle(32'h100, 1, 1, 6'd0, 0, 0, tk, ix, mi, mc, etk, eix);
        chk("same_cycle_old", tk, 1);
        cycle(32'h100, 1, 0, 6'd0, 0, 0, tk, ix, mi, mc, etk, eix);
        chk("same_cycle_new", tk, 0);

        // History effect on indexing.
        do_reset(1'b0);
        cycle(32'h0, 0, 1, 6'd0, 1, 1, tk, ix, mi, mc, etk, eix);
        cycle(32'h0, 0, 1, 6'd0, 1, 1, tk, ix, mi, mc, etk, eix);
        cycle(32'h100, 1, 0, 6'd0, 0, 0, tk, ix, mi, mc, etk, eix);
`ifdef BHT_GSHARE_EN
        chk("ghr_idx", ix, 3);
`else
        chk("ghr_idx", ix, 0);
`endif

        // Randomized traffic against the model, with small PC range for aliasing.
        do_reset(1'b0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                cycle({22'd0, 10'($urandom)}, 1'($urandom), 1'($urandom_range(0, 2) != 0),
                      6'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                      tk, ix, mi, mc, etk, eix);
                chk("rnd_taken", tk, etk);
                chk("rnd_idx", ix, eix);
                chk("rnd_mispredict", mi, m_mis);
                chk("rnd_cnt", mc, m_stat);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
